// File: rtl/conv_pkg.sv
// Shared definitions for the rate-1/2 convolutional encoder slice.
// Provides the framer state type, default code parameters and a reference
// symbol function usable by both the encoder and decoder-side models.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } conv_state_t;

  localparam int unsigned CONV_K         = 7;
  localparam logic [6:0]  CONV_G0        = 7'o171;
  localparam logic [6:0]  CONV_G1        = 7'o133;
  localparam int unsigned CONV_FRAME_LEN = 32;

  // Widest supported constraint length; the function operates on
  // zero-extended operands so one definition serves every K.
  localparam int unsigned CONV_KMAX = 9;

  // Code symbol {parity(g0 & v), parity(g1 & v)} with v = {d, sr}.
  // sr and the generators are right-aligned; d lands at bit k-1.
  function automatic logic [1:0] conv_symbol(
    input logic                 d,
    input logic [CONV_KMAX-2:0] sr,
    input logic [CONV_KMAX-1:0] g0,
    input logic [CONV_KMAX-1:0] g1,
    input int unsigned          k
  );
    logic [CONV_KMAX-1:0] v;
    v = {1'b0, sr} | (CONV_KMAX'(d) << (k - 1));
    return {^(g0 & v), ^(g1 & v)};
  endfunction

endpackage

// File: rtl/conv_tx_framer_core.sv
// Encoder core: K-1 bit shift register plus the generator parity pair.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset (clears sr)
//   step      - shift bit_in into the register this cycle
//   bit_in    - bit being encoded this cycle
//   sr        - register contents, sr[K-2] newest, sr[0] oldest
//   sym       - combinational symbol for bit_in against current sr
module conv_core
  import conv_pkg::*;
#(
  parameter int unsigned    K  = CONV_K,
  parameter logic [K-1:0]   G0 = K'(CONV_G0),
  parameter logic [K-1:0]   G1 = K'(CONV_G1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         bit_in,
  output logic [K-2:0] sr,
  output logic [1:0]   sym
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (step) begin
      sr <= {bit_in, sr[K-2:1]};
    end
  end

  always_comb begin
    sym = conv_symbol(bit_in, (CONV_KMAX-1)'(sr), CONV_KMAX'(G0),
                      CONV_KMAX'(G1), K);
  end

endmodule

// File: rtl/conv_tx_framer.sv
// Transmit framer: rate-1/2 convolutional encoder with FRAME_LEN data bits
// per frame followed by K-1 zero tail bits that return the trellis to 0.
// Supported K range is 3..9.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   enable_i     - information bit offered this cycle
//   d_in         - information bit
//   ready_o      - block accepts d_in this cycle (low during tail)
//   valid_o      - d_out holds a symbol
//   d_out        - {parity(G0&v), parity(G1&v)}, v = {d, sr}
//   sof_o, eof_o - first data symbol / last tail symbol of a frame
//   frame_cnt_o  - completed frame count, wraps
module conv_tx_framer
  import conv_pkg::*;
#(
  parameter int unsigned  K         = CONV_K,
  parameter logic [K-1:0] G0        = K'(CONV_G0),
  parameter logic [K-1:0] G1        = K'(CONV_G1),
  parameter int unsigned  FRAME_LEN = CONV_FRAME_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       ready_o,
  output logic       valid_o,
  output logic [1:0] d_out,
  output logic       sof_o,
  output logic       eof_o,
  output logic [7:0] frame_cnt_o
);

  localparam int unsigned BW = $clog2(FRAME_LEN + 1);
  localparam int unsigned TW = $clog2(K);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] LAST_TAIL = TW'(K - 2);

  conv_state_t   state, state_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [TW-1:0] tail_cnt, tail_cnt_n;
  logic [7:0]    frame_cnt_n;
  logic          valid_n, sof_n, eof_n;
  logic [1:0]    d_out_n;
  logic          step, core_bit, accept;
  logic [1:0]    sym;
  logic [K-2:0]  sr;

  conv_core #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .step   (step),
    .bit_in (core_bit),
    .sr     (sr),
    .sym    (sym)
  );

  assign ready_o = (state != TAIL);
  assign accept  = enable_i && ready_o;

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    tail_cnt_n  = tail_cnt;
    frame_cnt_n = frame_cnt_o;
    valid_n     = 1'b0;
    sof_n       = 1'b0;
    eof_n       = 1'b0;
    d_out_n     = '0;
    step        = 1'b0;
    core_bit    = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          step     = 1'b1;
          core_bit = d_in;
          valid_n  = 1'b1;
          sof_n    = 1'b1;
          d_out_n  = sym;
          if (FRAME_LEN == 1) begin
            state_n    = TAIL;
            tail_cnt_n = '0;
          end else begin
            state_n   = DATA;
            bit_cnt_n = BW'(1);
          end
        end
      end
      DATA: begin
        if (accept) begin
          step     = 1'b1;
          core_bit = d_in;
          valid_n  = 1'b1;
          d_out_n  = sym;
          if (bit_cnt == LAST_BIT) begin
            state_n    = TAIL;
            bit_cnt_n  = '0;
            tail_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
      end
      TAIL: begin
        // Zero is shifted in every cycle regardless of enable_i.
        step    = 1'b1;
        valid_n = 1'b1;
        d_out_n = sym;
        if (tail_cnt == LAST_TAIL) begin
          eof_n       = 1'b1;
          frame_cnt_n = frame_cnt_o + 8'd1;
          tail_cnt_n  = '0;
          state_n     = IDLE;
        end else begin
          tail_cnt_n = tail_cnt + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tail_cnt    <= '0;
      frame_cnt_o <= '0;
      valid_o     <= 1'b0;
      d_out       <= '0;
      sof_o       <= 1'b0;
      eof_o       <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      tail_cnt    <= tail_cnt_n;
      frame_cnt_o <= frame_cnt_n;
      valid_o     <= valid_n;
      d_out       <= d_out_n;
      sof_o       <= sof_n;
      eof_o       <= eof_n;
    end
  end

endmodule

// File: tb/tb_conv_tx_framer.sv
// Directed bench for conv_tx_framer: a small K=3 instance and a default
// K=7 instance, with an independent tap-history encoder model.
module tb_conv_tx_framer;

  logic       clk = 1'b0;
  logic       a_rst = 1'b0, a_en = 1'b0, a_d = 1'b0;
  logic       a_ready, a_valid, a_sof, a_eof;
  logic [1:0] a_dout;
  logic [7:0] a_fcnt;
  logic       b_rst = 1'b0, b_en = 1'b0, b_d = 1'b0;
  logic       b_ready, b_valid, b_sof, b_eof;
  logic [1:0] b_dout;
  logic [7:0] b_fcnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  logic [3:0]  mon_q[$];   // {sof, eof, d_out}
  int unsigned mon_t[$];
  logic [3:0]  exp_q[$];
  logic        stim_q[$];

  conv_tx_framer #(
    .K         (3),
    .G0        (3'o7),
    .G1        (3'o5),
    .FRAME_LEN (4)
  ) dut_a (
    .clk         (clk),
    .rst         (a_rst),
    .enable_i    (a_en),
    .d_in        (a_d),
    .ready_o     (a_ready),
    .valid_o     (a_valid),
    .d_out       (a_dout),
    .sof_o       (a_sof),
    .eof_o       (a_eof),
    .frame_cnt_o (a_fcnt)
  );

  conv_tx_framer dut_b (
    .clk         (clk),
    .rst         (b_rst),
    .enable_i    (b_en),
    .d_in        (b_d),
    .ready_o     (b_ready),
    .valid_o     (b_valid),
    .d_out       (b_dout),
    .sof_o       (b_sof),
    .eof_o       (b_eof),
    .frame_cnt_o (b_fcnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_valid) begin
      mon_q.push_back({a_sof, a_eof, a_dout});
      mon_t.push_back(cyc);
    end
    if (b_valid) begin
      mon_q.push_back({b_sof, b_eof, b_dout});
      mon_t.push_back(cyc);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    mon_q.delete();
    mon_t.delete();
    exp_q.delete();
    stim_q.delete();
  endtask

  task automatic do_reset(input bit on_b);
    a_en = 1'b0;
    b_en = 1'b0;
    @(negedge clk);
    #2;
    if (on_b) b_rst = 1'b0; else a_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (on_b) b_rst = 1'b1; else a_rst = 1'b1;
    tick();
  endtask

  // Offers stim_q bits with enable held high; a bit advances only when
  // ready was high at the edge.
  task automatic drive_stream(input bit on_b);
    int unsigned i = 0;
    int unsigned guard = 0;
    while (i < stim_q.size() && guard < 20000) begin
      bit acc;
      if (on_b) begin
        b_en = 1'b1; b_d = stim_q[i]; acc = b_ready;
      end else begin
        a_en = 1'b1; a_d = stim_q[i]; acc = a_ready;
      end
      tick();
      guard++;
      if (acc) i++;
    end
    a_en = 1'b0;
    b_en = 1'b0;
    check("drive_done", i, stim_q.size());
  endtask

  task automatic wait_syms(input int unsigned n);
    int unsigned guard = 0;
    while (mon_q.size() < n && guard < 200) begin
      tick();
      guard++;
    end
    tick();
  endtask

  // Independent model: h[m] is the bit seen m steps ago, tapped by g[k-1-m].
  task automatic model_stream(input int k, input logic [8:0] g0, input logic [8:0] g1,
                              input int flen);
    logic h[0:9];
    logic p0, p1, d;
    for (int f = 0; f < stim_q.size() / flen; f++) begin
      for (int m = 0; m < 10; m++) h[m] = 1'b0;
      for (int t = 0; t < flen + k - 1; t++) begin
        d = (t < flen) ? stim_q[f*flen + t] : 1'b0;
        h[0] = d;
        p0 = 1'b0;
        p1 = 1'b0;
        for (int m = 0; m < k; m++) begin
          p0 = p0 ^ (g0[k-1-m] & h[m]);
          p1 = p1 ^ (g1[k-1-m] & h[m]);
        end
        exp_q.push_back({(t == 0), (t == flen + k - 2), p0, p1});
        for (int m = 9; m > 0; m--) h[m] = h[m-1];
      end
    end
  endtask

  task automatic compare_q(input string tag, input bit per_sym);
    int unsigned n, bad;
    bit found = 0;
    check({tag, "_len"}, mon_q.size(), exp_q.size());
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    if (n == 0) return;
    bad = n - 1;
    for (int unsigned i = 0; i < n; i++) begin
      if (per_sym) check({tag, "_sym"}, mon_q[i], exp_q[i]);
      else if (!found && mon_q[i] !== exp_q[i]) begin
        bad = i;
        found = 1;
      end
    end
    if (!per_sym) check(tag, mon_q[bad], exp_q[bad]);
  endtask

  initial begin
    logic bits1[4];
    int unsigned eofs;
    bits1 = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Reset state
    #12;
    check("rst_valid", a_valid, 1'b0);
    check("rst_dout", a_dout, 2'b00);
    check("rst_sof_eof", {a_sof, a_eof}, 2'b00);
    check("rst_ready", a_ready, 1'b1);
    check("rst_fcnt", a_fcnt, 8'd0);
    @(negedge clk);
    a_rst = 1'b1;
    b_rst = 1'b1;
    tick();

    // Test 1: K=3 (7,5), bits 1,0,1,1 consecutive
    clear_q();
    for (int i = 0; i < 4; i++) begin
      a_en = 1'b1;
      a_d  = bits1[i];
      tick();
    end
    a_en = 1'b0;
    check("t1_ready_tail0", a_ready, 1'b0);
    tick();
    check("t1_ready_tail1", a_ready, 1'b0);
    tick();
    check("t1_ready_idle", a_ready, 1'b1);
    check("t1_fcnt", a_fcnt, 8'd1);
    exp_q = '{4'b1011, 4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0111};
    wait_syms(6);
    compare_q("t1", 1'b1);

    // Test 2: enable toggled, gaps one cycle after each enable low
    clear_q();
    for (int i = 0; i < 4; i++) begin
      a_en = 1'b1;
      a_d  = bits1[i];
      tick();
      check("t2_valid_on", a_valid, 1'b1);
      a_en = 1'b0;
      tick();
      if (i < 3) check("t2_valid_gap", a_valid, 1'b0);
    end
    exp_q = '{4'b1011, 4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0111};
    wait_syms(6);
    compare_q("t2", 1'b1);
    check("t2_fcnt", a_fcnt, 8'd2);

    // Test 3: default config, all-zero frame
    clear_q();
    for (int i = 0; i < 32; i++) stim_q.push_back(1'b0);
    for (int i = 0; i < 38; i++) exp_q.push_back({(i == 0), (i == 37), 2'b00});
    drive_stream(1'b1);
    wait_syms(38);
    compare_q("t3", 1'b0);
    check("t3_sr_zero", dut_b.u_core.sr, 0);
    check("t3_fcnt", b_fcnt, 8'd1);

    // Test 4: two frames back-to-back, enable held high through tail
    do_reset(1'b0);
    clear_q();
    stim_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    model_stream(3, 9'o7, 9'o5, 4);
    drive_stream(1'b0);
    wait_syms(12);
    compare_q("t4", 1'b1);
    if (mon_t.size() >= 7) check("t4_sof_after_eof", mon_t[6] - mon_t[5], 1);
    else check("t4_sym_count", mon_t.size(), 12);
    check("t4_fcnt", a_fcnt, 8'd2);

    // Test 5: asynchronous reset after the 10th data bit
    clear_q();
    for (int i = 0; i < 10; i++) begin
      b_en = 1'b1;
      b_d  = 1'($urandom_range(1, 0));
      tick();
    end
    #3;
    b_rst = 1'b0;
    #1;
    check("t5_valid", b_valid, 1'b0);
    check("t5_dout", b_dout, 2'b00);
    check("t5_sof_eof", {b_sof, b_eof}, 2'b00);
    check("t5_ready", b_ready, 1'b1);
    check("t5_fcnt", b_fcnt, 8'd0);
    b_en = 1'b0;
    tick();
    @(negedge clk);
    b_rst = 1'b1;
    tick();
    eofs = 0;
    foreach (mon_q[i]) if (mon_q[i][2]) eofs++;
    check("t5_no_eof", eofs, 0);
    clear_q();
    for (int i = 0; i < 32; i++) stim_q.push_back(1'($urandom_range(1, 0)));
    model_stream(7, 9'o171, 9'o133, 32);
    drive_stream(1'b1);
    wait_syms(38);
    compare_q("t5_fresh", 1'b0);
    check("t5_fcnt_after", b_fcnt, 8'd1);

    // Test 6: 256 random frames, counter wraps to 0
    do_reset(1'b1);
    for (int f = 0; f < 256; f++) begin
      clear_q();
      for (int i = 0; i < 32; i++) stim_q.push_back(1'($urandom_range(1, 0)));
      model_stream(7, 9'o171, 9'o133, 32);
      drive_stream(1'b1);
      wait_syms(38);
      compare_q("t6_frame", 1'b0);
      if (f == 254) check("t6_fcnt_255", b_fcnt, 8'd255);
    end
    check("t6_fcnt_wrap", b_fcnt, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
